// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - md_unit op encodings, FSM states and op-class helpers (MD_UNIT_MADD_EN enables MADD/MSUB)
package md_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MADD  = 4'd7,
        MD_MADDU = 4'd8,
        MD_MSUB  = 4'd9,
        MD_MSUBU = 4'd10
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // Ops that occupy the unit for MUL_CYCLES; the accumulate family exists only with the macro
    function automatic logic is_mul_op(input logic [3:0] op);
        case (op)
            MD_MULT, MD_MULTU: return 1'b1;
`ifdef MD_UNIT_MADD_EN
            MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_latency_counter.sv
// rtl/md_latency_counter.sv - loadable down-counter; done is high while the count sits at 1
module md_latency_counter #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          done
);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == CW'(1));

endmodule

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle multiply/divide unit with HI/LO registers (MD_UNIT_MADD_EN enables MADD/MSUB)
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       md_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    md_state_e        state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic             cnt_load, cnt_done;
    logic [CW-1:0]    cnt_val;

    md_latency_counter #(.CW(CW)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .done     (cnt_done)
    );

    // Results are pure combinational functions of the latched operands
    logic                   op_signed;
    logic [2*WIDTH-1:0]     prod_s, prod_u, prod;
    logic signed [WIDTH-1:0] sa, sb;
    logic [WIDTH-1:0]       quo_s, rem_s, res_hi, res_lo;

    assign op_signed = (op_q == MD_MULT) || (op_q == MD_MADD) || (op_q == MD_MSUB);
    assign prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
    assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    assign prod   = op_signed ? prod_s : prod_u;
    assign sa     = a_q;
    assign sb     = b_q;
    assign quo_s  = sa / sb;
    assign rem_s  = sa % sb;

    always_comb begin
        res_hi = hi_q;
        res_lo = lo_q;
        case (op_q)
            MD_MULT, MD_MULTU: {res_hi, res_lo} = prod;
            MD_DIV: begin
                if (b_q == '0) begin
                    res_lo = '1;
                    res_hi = a_q;
                end else if (a_q == MIN_VAL && b_q == '1) begin
                    res_lo = MIN_VAL;
                    res_hi = '0;
                end else begin
                    res_lo = quo_s;
                    res_hi = rem_s;
                end
            end
            MD_DIVU: begin
                if (b_q == '0) begin
                    res_lo = '1;
                    res_hi = a_q;
                end else begin
                    res_lo = a_q / b_q;
                    res_hi = a_q % b_q;
                end
            end
`ifdef MD_UNIT_MADD_EN
            MD_MADD, MD_MADDU: {res_hi, res_lo} = {hi_q, lo_q} + prod;
            MD_MSUB, MD_MSUBU: {res_hi, res_lo} = {hi_q, lo_q} - prod;
`endif
            default: ;
        endcase
    end

    // A start in the commit cycle is taken so back-to-back ops keep busy continuous
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_load = 1'b0;
        cnt_val  = '0;
        if (state_q == ST_RUN && cnt_done) begin
            hi_d    = res_hi;
            lo_d    = res_lo;
            state_d = ST_IDLE;
        end
        if (start && (state_q == ST_IDLE || cnt_done)) begin
            if (is_mul_op(md_op) || is_div_op(md_op)) begin
                state_d  = ST_RUN;
                op_d     = md_op;
                a_d      = a;
                b_d      = b;
                cnt_load = 1'b1;
                cnt_val  = is_div_op(md_op) ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
            end else if (state_q == ST_IDLE && md_op == MD_MTHI) begin
                hi_d = a;
            end else if (state_q == ST_IDLE && md_op == MD_MTLO) begin
                lo_d = a;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
